// File: rtl/pla_pkg.sv
// ============================================================================
// Module  : pla_pkg
// Brief   : Cell codes and loader FSM encoding for the PLA personality loader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pla_pkg;

    localparam logic [1:0] CELL_ZERO    = 2'b00;
    localparam logic [1:0] CELL_ONE     = 2'b01;
    localparam logic [1:0] CELL_DC      = 2'b10;
    localparam logic [1:0] CELL_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/pla_row_assembler.sv
// ============================================================================
// Module  : pla_row_assembler
// Brief   : Column counter plus value/care-mask shift registers for one row.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pla_row_assembler
    import pla_pkg::*;
#(
    parameter int N_COLS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift,
    input  logic              clear,
    input  logic [1:0]        code,
    output logic [N_COLS-1:0] row_value,
    output logic [N_COLS-1:0] row_mask,
    output logic [N_COLS-1:0] value_next,
    output logic [N_COLS-1:0] mask_next,
    output logic              last_cell,
    output logic              row_full,
    output logic              illegal_seen
);

    localparam int COL_W = $clog2(N_COLS + 1);

    logic [COL_W-1:0]  col_q,   col_d;
    logic [N_COLS-1:0] value_q, value_d;
    logic [N_COLS-1:0] mask_q,  mask_d;

    // Shift left so the first cell of a row ends up in the MSB.
    always_comb begin
        value_next = {value_q[N_COLS-2:0], (code == CELL_ONE)};
        mask_next  = {mask_q[N_COLS-2:0],  (code != CELL_DC)};
        col_d      = col_q;
        value_d    = value_q;
        mask_d     = mask_q;
        if (clear) begin
            col_d   = '0;
            value_d = '0;
            mask_d  = '0;
        end else if (shift) begin
            col_d   = col_q + COL_W'(1);
            value_d = value_next;
            mask_d  = mask_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q   <= '0;
            value_q <= '0;
            mask_q  <= '0;
        end else begin
            col_q   <= col_d;
            value_q <= value_d;
            mask_q  <= mask_d;
        end
    end

    assign row_value    = value_q;
    assign row_mask     = mask_q;
    assign last_cell    = (col_q == COL_W'(N_COLS - 1));
    assign row_full     = (col_q == COL_W'(N_COLS));
    assign illegal_seen = (code == CELL_ILLEGAL);

endmodule

`default_nettype wire

// File: rtl/pla_personality_loader.sv
// ============================================================================
// Module  : pla_personality_loader
// Brief   : Serial ternary-cell loader issuing row writes to the PLA AND plane.
//           Define ROW_PARITY_EN to require a parity symbol after each row.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pla_personality_loader
    import pla_pkg::*;
#(
    parameter int N_ROWS = 3,
    parameter int N_COLS = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ser_valid,
    input  logic [1:0]        ser_data,
    output logic              ser_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [N_COLS-1:0] wr_value,
    output logic [N_COLS-1:0] wr_mask,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [N_COLS-1:0] wr_value_q, wr_value_d;
    logic [N_COLS-1:0] wr_mask_q, wr_mask_d;

    logic              asm_shift, asm_clear;
    logic [N_COLS-1:0] row_value, row_mask, value_next, mask_next;
    logic [N_COLS-1:0] cap_value, cap_mask;
    logic              last_cell, row_full, illegal_seen;

    pla_row_assembler #(
        .N_COLS (N_COLS)
    ) u_row_assembler (
        .clk          (clk),
        .rst          (rst),
        .shift        (asm_shift),
        .clear        (asm_clear),
        .code         (ser_data),
        .row_value    (row_value),
        .row_mask     (row_mask),
        .value_next   (value_next),
        .mask_next    (mask_next),
        .last_cell    (last_cell),
        .row_full     (row_full),
        .illegal_seen (illegal_seen)
    );

    // A full row is only stored when a parity symbol is being consumed;
    // otherwise the write takes the row including the incoming last cell.
    assign cap_value = row_full ? row_value : value_next;
    assign cap_mask  = row_full ? row_mask  : mask_next;

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        wr_addr_d  = wr_addr_q;
        wr_value_d = wr_value_q;
        wr_mask_d  = wr_mask_q;
        asm_shift  = 1'b0;
        asm_clear  = 1'b0;
        ser_ready  = 1'b0;
        busy       = 1'b0;
        wr_en      = 1'b0;
        done       = 1'b0;
        err        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_SHIFT;
                    row_d     = '0;
                    asm_clear = 1'b1;
                end
            end

            ST_SHIFT: begin
                ser_ready = 1'b1;
                busy      = 1'b1;
`ifdef ROW_PARITY_EN
                if (ser_valid && row_full) begin
                    if (ser_data == {1'b0, ^row_value}) begin
                        state_d    = ST_WRITE;
                        wr_addr_d  = row_q;
                        wr_value_d = cap_value;
                        wr_mask_d  = cap_mask;
                    end else begin
                        state_d = ST_ERR;
                    end
                end else if (ser_valid) begin
                    if (illegal_seen) begin
                        state_d = ST_ERR;
                    end else begin
                        asm_shift = 1'b1;
                    end
                end
`else
                if (ser_valid) begin
                    if (illegal_seen) begin
                        state_d = ST_ERR;
                    end else begin
                        asm_shift = 1'b1;
                        if (last_cell) begin
                            state_d    = ST_WRITE;
                            wr_addr_d  = row_q;
                            wr_value_d = cap_value;
                            wr_mask_d  = cap_mask;
                        end
                    end
                end
`endif
            end

            ST_WRITE: begin
                busy      = 1'b1;
                wr_en     = 1'b1;
                asm_clear = 1'b1;
                if (row_q == ADDR_W'(N_ROWS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    row_d   = row_q + ADDR_W'(1);
                    state_d = ST_SHIFT;
                end
            end

            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            ST_ERR: begin
                err = 1'b1;
                if (start) begin
                    state_d   = ST_SHIFT;
                    row_d     = '0;
                    asm_clear = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            wr_addr_q  <= '0;
            wr_value_q <= '0;
            wr_mask_q  <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            wr_addr_q  <= wr_addr_d;
            wr_value_q <= wr_value_d;
            wr_mask_q  <= wr_mask_d;
        end
    end

    assign wr_addr  = wr_addr_q;
    assign wr_value = wr_value_q;
    assign wr_mask  = wr_mask_q;

endmodule

`default_nettype wire

// File: tb/tb_pla_personality_loader.sv
// ============================================================================
// Module  : tb_pla_personality_loader
// Brief   : Scoreboard bench for pla_personality_loader (ROW_PARITY_EN aware).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pla_personality_loader;

    typedef struct packed {
        logic [1:0] addr;
        logic [3:0] value;
        logic [3:0] mask;
    } wr_t;

    localparam logic [7:0] ROW_A = 8'b01_10_00_10;  // 1?0?
    localparam logic [7:0] ROW_B = 8'b01_01_10_00;  // 11?0
    localparam logic [7:0] ROW_C = 8'b00_10_10_00;  // 0??0

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       ser_valid = 1'b0;
    logic [1:0] ser_data = 2'b00;
    logic       ser_ready, wr_en, busy, done, err;
    logic [1:0] wr_addr;
    logic [3:0] wr_value, wr_mask;

    int  n_checks = 0;
    int  n_fail   = 0;
    int  wr_cnt   = 0;
    int  done_cnt = 0;
    wr_t sb[$];
    wr_t mon_e;

    pla_personality_loader #(
        .N_ROWS (3),
        .N_COLS (4),
        .ADDR_W (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ser_valid (ser_valid),
        .ser_data  (ser_data),
        .ser_ready (ser_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_value  (wr_value),
        .wr_mask   (wr_mask),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Write monitor: every wr_en pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_cnt++;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL wr_unexpected: got addr=%0d value=%b mask=%b, expected no write",
                         wr_addr, wr_value, wr_mask);
            end else begin
                mon_e = sb.pop_front();
                if ({wr_addr, wr_value, wr_mask} !== mon_e) begin
                    n_fail++;
                    $display("FAIL wr_data: got addr=%0d value=%b mask=%b, expected addr=%0d value=%b mask=%b",
                             wr_addr, wr_value, wr_mask, mon_e.addr, mon_e.value, mon_e.mask);
                end
            end
        end
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic wr_t model_row(input logic [1:0] addr, input logic [7:0] r);
        wr_t e;
        e.addr = addr;
        for (int c = 0; c < 4; c++) begin
            e.value[3-c] = (r[7-2*c -: 2] == 2'b01);
            e.mask[3-c]  = (r[7-2*c -: 2] != 2'b10);
        end
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send_cell(input logic [1:0] code);
        bit ok;
        ok        = 1'b0;
        ser_data  = code;
        ser_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (ser_ready === 1'b1) begin
                ok = 1'b1;
                tick(1);
                break;
            end
            tick(1);
        end
        ser_valid = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL send_timeout: ser_ready=%b after 40 cycles, expected 1", ser_ready);
        end
    endtask

    task automatic send_row(input logic [7:0] r);
        wr_t e;
        for (int c = 0; c < 4; c++) send_cell(r[7-2*c -: 2]);
`ifdef ROW_PARITY_EN
        e = model_row(2'd0, r);
        send_cell({1'b0, ^e.value});
`else
        e = '0;
`endif
    endtask

    task automatic push_std();
        sb.push_back(model_row(2'd0, ROW_A));
        sb.push_back(model_row(2'd1, ROW_B));
        sb.push_back(model_row(2'd2, ROW_C));
    endtask

    task automatic check_load_end(input string name, input int w0, input int d0, input int nw, input int nd);
        n_checks++;
        if ((wr_cnt - w0) !== nw) begin
            n_fail++;
            $display("FAIL %s_writes: got %0d, expected %0d", name, wr_cnt - w0, nw);
        end
        n_checks++;
        if ((done_cnt - d0) !== nd) begin
            n_fail++;
            $display("FAIL %s_done: got %0d pulses, expected %0d", name, done_cnt - d0, nd);
        end
        n_checks++;
        if (busy !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_idle: got busy=%b pending=%0d, expected busy=0 pending=0",
                     name, busy, sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        n_checks++;
        if ({ser_ready, wr_en, busy, done, err, wr_addr, wr_value, wr_mask} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, expected all zero",
                     {ser_ready, wr_en, busy, done, err, wr_addr, wr_value, wr_mask});
        end
        rst = 1'b0;
        tick(2);
        n_checks++;
        if ({ser_ready, busy, err} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_after_reset: got ready/busy/err=%b, expected 000", {ser_ready, busy, err});
        end
    endtask

    task automatic test_basic();
        int w0, d0;
        w0 = wr_cnt; d0 = done_cnt;
        push_std();
        pulse_start();
        n_checks++;
        if ({busy, ser_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL basic_busy: got busy/ready=%b, expected 11", {busy, ser_ready});
        end
        send_row(ROW_A);
        send_row(ROW_B);
        send_row(ROW_C);
        tick(6);
        check_load_end("basic", w0, d0, 3, 1);
    endtask

    task automatic test_stall();
        int w0, d0;
        w0 = wr_cnt; d0 = done_cnt;
        push_std();
        pulse_start();
        send_row(ROW_A);
        send_cell(2'b01);
        send_cell(2'b01);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (ser_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_ready: got %b at stall cycle %0d, expected 1", ser_ready, i);
            end
            tick(1);
        end
        send_cell(2'b10);
        send_cell(2'b00);
`ifdef ROW_PARITY_EN
        send_cell(2'b00);
`endif
        send_row(ROW_C);
        tick(6);
        check_load_end("stall", w0, d0, 3, 1);
    endtask

    task automatic test_illegal();
        int w0, d0;
        w0 = wr_cnt; d0 = done_cnt;
        sb.push_back(model_row(2'd0, ROW_A));
        pulse_start();
        send_row(ROW_A);
        send_cell(2'b01);
        send_cell(2'b01);
        send_cell(2'b11);
        tick(4);
        n_checks++;
        if ({err, busy, ser_ready} !== 3'b100) begin
            n_fail++;
            $display("FAIL illegal_err: got err/busy/ready=%b, expected 100", {err, busy, ser_ready});
        end
        check_load_end("illegal", w0, d0, 1, 0);
        w0 = wr_cnt; d0 = done_cnt;
        push_std();
        pulse_start();
        n_checks++;
        if ({err, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL err_clear: got err/busy=%b, expected 01", {err, busy});
        end
        send_row(ROW_A);
        send_row(ROW_B);
        send_row(ROW_C);
        tick(6);
        check_load_end("recover", w0, d0, 3, 1);
    endtask

    task automatic test_reset_midload();
        int w0, d0;
        w0 = wr_cnt; d0 = done_cnt;
        sb.push_back(model_row(2'd0, ROW_A));
        pulse_start();
        send_row(ROW_A);
        send_cell(2'b01);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({ser_ready, wr_en, busy, done, err, wr_addr, wr_value, wr_mask} !== 15'd0) begin
            n_fail++;
            $display("FAIL midload_reset: got %b, expected all zero",
                     {ser_ready, wr_en, busy, done, err, wr_addr, wr_value, wr_mask});
        end
        tick(1);
        rst = 1'b0;
        tick(4);
        check_load_end("midload", w0, d0, 1, 0);
        w0 = wr_cnt; d0 = done_cnt;
        push_std();
        pulse_start();
        send_row(ROW_A);
        send_row(ROW_B);
        send_row(ROW_C);
        tick(6);
        check_load_end("reload", w0, d0, 3, 1);
    endtask

    task automatic test_start_ignored();
        int w0, d0;
        w0 = wr_cnt; d0 = done_cnt;
        push_std();
        pulse_start();
        send_row(ROW_A);
        send_cell(2'b01);
        send_cell(2'b01);
        pulse_start();
        send_cell(2'b10);
        send_cell(2'b00);
`ifdef ROW_PARITY_EN
        send_cell(2'b00);
`endif
        send_row(ROW_C);
        tick(6);
        check_load_end("start_ignored", w0, d0, 3, 1);
    endtask

`ifdef ROW_PARITY_EN
    task automatic test_parity();
        int w0, d0;
        w0 = wr_cnt; d0 = done_cnt;
        sb.push_back(model_row(2'd0, ROW_A));
        pulse_start();
        send_row(ROW_A);
        for (int c = 0; c < 4; c++) send_cell(ROW_A[7-2*c -: 2]);
        send_cell(2'b00);
        tick(4);
        n_checks++;
        if ({err, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL parity_err: got err/busy=%b, expected 10", {err, busy});
        end
        check_load_end("parity", w0, d0, 1, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_illegal();
        test_reset_midload();
        test_start_ignored();
`ifdef ROW_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pla_personality_loader.md
Name: pla_personality_loader

Overview:
Upstream programming stage for the PLA AND-plane personality memory. Accepts a serial stream of ternary cell codes (0 / 1 / don't-care), assembles one product-term row at a time, and issues one-cycle row writes (value + care mask) into the personality array consumed by the PLA plane. Used at configuration time, before the plane evaluates inputs.

Parameters:
N_ROWS, 3, number of product-term rows (functions) in the personality matrix
N_COLS, 4, cells per row (input variables per term)
ADDR_W, 2, width of row address; must satisfy 2**ADDR_W >= N_ROWS

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse, begins a load of all N_ROWS rows
ser_valid  in  1  cell code on ser_data is valid
ser_data  in  2  cell code: 00 = 0, 01 = 1, 10 = don't-care, 11 = illegal
ser_ready  out  1  loader accepts a cell this cycle (accept = ser_valid & ser_ready)
wr_en  out  1  one-cycle row write strobe
wr_addr  out  ADDR_W  row index being written
wr_value  out  N_COLS  cell values; bit is 0 where the cell is don't-care
wr_mask  out  N_COLS  1 = care cell, 0 = don't-care
busy  out  1  load in progress
done  out  1  one-cycle pulse after the last row is written
err  out  1  sticky error; illegal code or parity failure

Behaviour:
- Reset: FSM = IDLE, all outputs 0, row and column counters 0, row shift register cleared.
- States: IDLE, SHIFT, WRITE, DONE, ERR.
- IDLE: ser_ready = 0. start -> SHIFT with row = 0, col = 0, err cleared.
- SHIFT: ser_ready = 1, busy = 1. Each accepted cell fills column col; column 0 arrives first and maps to wr_value/wr_mask bit N_COLS-1 (MSB-first, matching the [0:N-1] personality ordering). Accepting code 11 -> ERR; that row is not written. After cell N_COLS-1 is accepted -> WRITE. ser_valid low: hold, no state change.
- WRITE: ser_ready = 0; wr_en = 1 for exactly one cycle with wr_addr = row. Latency: wr_en rises the cycle after the last cell of the row is accepted. If row == N_ROWS-1 -> DONE; otherwise row++, col = 0 -> SHIFT.
- DONE: done = 1 for one cycle, busy = 0, -> IDLE.
- ERR: err = 1 (held), busy = 0, ser_ready = 0, no writes. start -> SHIFT at row 0 with err cleared. Otherwise remain.
- start while in SHIFT or WRITE is ignored.
- rst asserted mid-load aborts immediately: no further wr_en; rows already written are not undone.
- wr_value, wr_mask, and wr_addr are registered. They are valid only while wr_en = 1 and hold their last value otherwise.

Optional Feature:
ROW_PARITY_EN
- Defined: after the N_COLS cells of each row, SHIFT accepts one extra parity symbol. ser_data[0] must equal the XOR of the row's care-cell values (even parity over wr_value); ser_data[1] must be 0. A mismatch -> ERR and the row is not written. A match -> WRITE.
- Undefined: no parity symbol; a row goes to WRITE directly after cell N_COLS-1.

Decomposition:
- Package pla_pkg: cell code constants (CELL_ZERO, CELL_ONE, CELL_DC, CELL_ILLEGAL) and the FSM state encoding.
- Sub-module pla_row_assembler: column counter plus value/mask shift registers. Inputs: shift, clear. Outputs: row_full, illegal_seen.
- The FSM and row counter stay in pla_personality_loader.

Test Plan:
- Default params, load rows 1?0? / 11?0 / 0??0 (codes 01,10,00,10 / 01,01,10,00 / 00,10,10,00) -> three wr_en pulses: addr 0 value 1000 mask 1010; addr 1 value 1100 mask 1101; addr 2 value 0000 mask 1001; then done pulse, busy low.
- Same stream with ser_valid deasserted for 3 cycles mid-row 1 -> identical writes, no extra wr_en; ser_ready stays 1 during the stall.
- Code 11 as cell 2 of row 1 -> row 0 written, err = 1, no row 1/2 writes. A later start with a clean stream -> err clears and all 3 rows are written.
- rst pulsed after row 0 write while in SHIFT -> all outputs 0 next cycle, no further wr_en. A start afterwards reloads from row 0.
- start pulsed during SHIFT of row 1 -> ignored; load completes normally with exactly 3 writes.
- ROW_PARITY_EN: row 1?0? with parity 1 -> written. Same row with parity 0 -> err, no write.
